// File: rtl/cla_pkg.sv
// cla_pkg: constants, block-count helper and result types
// shared by the carry-lookahead add/subtract family.
package cla_pkg;

  localparam int BLOCK_SIZE = 4;
  localparam int RESULT_W   = 32;

  function automatic int num_blocks(input int width);
    return width / BLOCK_SIZE;
  endfunction

  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
  } cla_flags_t;

  // Full result beat at the default operand width.
  typedef struct packed {
    logic [RESULT_W-1:0] diff;
    cla_flags_t          flags;
  } cla_result_t;

endpackage

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead block with block
// propagate/generate outputs for a second-level lookahead.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       p,
  output logic       g
);

  logic [3:0] pi;
  logic [3:0] gi;
  logic [3:0] c;

  assign pi = a ^ b;
  assign gi = a & b;

  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0])
              | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1])
              | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  assign sum = pi ^ c;
  assign p   = &pi;
  assign g   = gi[3]
             | (pi[3] & gi[2])
             | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);

endmodule

// File: rtl/pipelined_cla_subtractor.sv
// pipelined_cla_subtractor: two-stage CLA computing A - B - Bin
// with valid/ready on both ends and borrow/overflow/zero flags.
module pipelined_cla_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int BLOCK_SIZE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int NB = num_blocks(WIDTH);

  if ((WIDTH % BLOCK_SIZE) != 0 ||
      BLOCK_SIZE != cla_pkg::BLOCK_SIZE) begin : g_bad_cfg
    $fatal(1, "WIDTH must be a multiple of a 4-bit block");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] nb;
    logic             cin;
    logic [NB-1:0]    p;
    logic [NB-1:0]    g;
    logic             a_msb;
    logic             b_msb;
  } s1_t;

  logic       s1_valid;
  s1_t        s1;
  s1_t        s1_d;
  logic       s2_adv;
  logic       accept;
  cla_flags_t flags_q;
  cla_flags_t flags_c;

  logic [WIDTH-1:0] nb_in;
  logic [NB-1:0]    pg_p;
  logic [NB-1:0]    pg_g;
  logic [NB:0]      carry;
  logic [WIDTH-1:0] diff_c;

  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign accept   = in_valid & in_ready;

  assign nb_in = ~B;

  // Stage 1: block P/G only; the carry-in is resolved next cycle.
  for (genvar i = 0; i < NB; i++) begin : g_pg
    logic [3:0] sum_unused;
    cla_4bit u_pg (
      .a   (A[i*BLOCK_SIZE +: BLOCK_SIZE]),
      .b   (nb_in[i*BLOCK_SIZE +: BLOCK_SIZE]),
      .cin (1'b0),
      .sum (sum_unused),
      .p   (pg_p[i]),
      .g   (pg_g[i])
    );
  end

  always_comb begin
    s1_d       = '0;
    s1_d.a     = A;
    s1_d.nb    = nb_in;
    s1_d.cin   = ~Bin;
    s1_d.p     = pg_p;
    s1_d.g     = pg_g;
    s1_d.a_msb = A[WIDTH-1];
    s1_d.b_msb = B[WIDTH-1];
  end

  // Stage 2: block carries ripple through the registered P/G.
  assign carry[0] = s1.cin;

  for (genvar i = 0; i < NB; i++) begin : g_sum
    logic p_unused;
    logic g_unused;
    assign carry[i+1] = s1.g[i] | (s1.p[i] & carry[i]);
    cla_4bit u_sum (
      .a   (s1.a[i*BLOCK_SIZE +: BLOCK_SIZE]),
      .b   (s1.nb[i*BLOCK_SIZE +: BLOCK_SIZE]),
      .cin (carry[i]),
      .sum (diff_c[i*BLOCK_SIZE +: BLOCK_SIZE]),
      .p   (p_unused),
      .g   (g_unused)
    );
  end

  always_comb begin
    flags_c      = '0;
    flags_c.bout = ~carry[NB];
    flags_c.ovf  = (s1.a_msb != s1.b_msb) &
                   (diff_c[WIDTH-1] != s1.a_msb);
    flags_c.zero = (diff_c == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1       <= s1_d;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Diff      <= '0;
      flags_q   <= '0;
    end else begin
      if (s2_adv) begin
        out_valid <= 1'b1;
        Diff      <= diff_c;
        flags_q   <= flags_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign Bout = flags_q.bout;
  assign Ovf  = flags_q.ovf;
  assign Zero = flags_q.zero;

endmodule
